// File: rtl/sec_remainder_locator.sv
// Sequential single-error locator for the A=4547 product code: maps a remainder
// r back to the signed bit position l with r == +/-2^(|l|-1) mod A.
module sec_remainder_locator #(
  parameter int A    = 4547,
  parameter int RW   = 13,
  parameter int NPOS = 29,
  parameter int LW   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] r_in,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] l_out,
  output logic          no_err,
  output logic          uncorr
);

  localparam int IW = $clog2(NPOS + 1);
  localparam logic [RW-1:0] A_L    = RW'(A);
  localparam logic [RW-1:0] P_ONE  = RW'(1);
  localparam logic [IW-1:0] I_ONE  = IW'(1);
  localparam logic [IW-1:0] NPOS_L = IW'(NPOS);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [RW-1:0] p_q, p_d;
  logic [IW-1:0] i_q, i_d;
  logic          z_q, z_d;
  logic          inv_q, inv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [LW-1:0] l_q, l_d;
  logic          no_err_q, no_err_d;
  logic          uncorr_q, uncorr_d;

  // p tracks 2^(i-1) mod A; doubling needs one extra bit before reduction.
  logic [RW:0]   p_dbl;
  logic [RW-1:0] p_next;
  logic [RW-1:0] p_neg;
  logic          accept;
  logic          finish;

  always_comb begin
    p_dbl  = {p_q, 1'b0};
    p_next = (p_dbl >= {1'b0, A_L}) ? RW'(p_dbl - {1'b0, A_L}) : p_dbl[RW-1:0];
    p_neg  = A_L - p_q;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    p_d      = p_q;
    i_d      = i_q;
    z_d      = z_q;
    inv_d    = inv_q;
    busy_d   = busy_q;
    done_d   = done_q;
    l_d      = l_q;
    no_err_d = no_err_q;
    uncorr_d = uncorr_q;
    accept   = 1'b0;
    finish   = 1'b0;

    case (state_q)
      IDLE: begin
        accept = start;
      end
      SEARCH: begin
        // Priority order matters: flag cases resolve on the first search edge.
        if (z_q) begin
          no_err_d = 1'b1;
          l_d      = '0;
          finish   = 1'b1;
        end else if (inv_q) begin
          uncorr_d = 1'b1;
          l_d      = '0;
          finish   = 1'b1;
        end else if (p_q == r_q) begin
          l_d    = LW'(i_q);
          finish = 1'b1;
        end else if (p_neg == r_q) begin
          l_d    = -LW'(i_q);
          finish = 1'b1;
        end else if (i_q == NPOS_L) begin
          uncorr_d = 1'b1;
          l_d      = '0;
          finish   = 1'b1;
        end else begin
          p_d = p_next;
          i_d = i_q + I_ONE;
        end
      end
      DONE: begin
        done_d = 1'b0;
        if (start) begin
          accept = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      state_d = DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    if (accept) begin
      state_d  = SEARCH;
      r_d      = r_in;
      p_d      = P_ONE;
      i_d      = I_ONE;
      z_d      = (r_in == '0);
      inv_d    = (r_in >= A_L);
      busy_d   = 1'b1;
      done_d   = 1'b0;
      l_d      = '0;
      no_err_d = 1'b0;
      uncorr_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      p_q      <= P_ONE;
      i_q      <= I_ONE;
      z_q      <= 1'b0;
      inv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      l_q      <= '0;
      no_err_q <= 1'b0;
      uncorr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      p_q      <= p_d;
      i_q      <= i_d;
      z_q      <= z_d;
      inv_q    <= inv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      l_q      <= l_d;
      no_err_q <= no_err_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign l_out  = l_q;
  assign no_err = no_err_q;
  assign uncorr = uncorr_q;

endmodule

// File: tb/tb_sec_remainder_locator.sv
// Self-checking bench for sec_remainder_locator: directed cases, a chained
// back-to-back sweep over golden and random remainders, and reset robustness.
module tb_sec_remainder_locator;

  localparam int A    = 4547;
  localparam int NPOS = 29;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] r_in;
  logic        busy;
  logic        done;
  logic [5:0]  l_out;
  logic        no_err;
  logic        uncorr;

  int n_checks = 0;
  int n_fail   = 0;

  sec_remainder_locator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .r_in   (r_in),
    .busy   (busy),
    .done   (done),
    .l_out  (l_out),
    .no_err (no_err),
    .uncorr (uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: brute-force search of r == +/-2^(k-1) mod A in ascending k.
  task automatic model(input int r, output int l, output int lat,
                       output int ne, output int uc);
    longint pw;
    l = 0; lat = 1; ne = 0; uc = 0;
    if (r == 0) begin
      ne = 1;
    end else if (r >= A) begin
      uc = 1;
    end else begin
      uc = 1; lat = NPOS;
      for (int k = 1; k <= NPOS; k++) begin
        pw = (longint'(1) << (k - 1)) % A;
        if (r == int'(pw)) begin
          l = k; lat = k; uc = 0; break;
        end
        if (r == A - int'(pw)) begin
          l = -k; lat = k; uc = 0; break;
        end
      end
    end
  endtask

  function automatic int sl(input logic [5:0] v);
    return int'($signed(v));
  endfunction

  // Called at a negedge; start/r_in are driven so the next posedge is E0.
  task automatic launch(input int r);
    start = 1'b1;
    r_in  = 13'(r);
  endtask

  // Waits out one search and checks latency and result against the model.
  // pulse_n > 0 drives a stray start with pulse_r during the search.
  task automatic collect(input int r, input int pulse_n, input int pulse_r);
    int l, lat, ne, uc;
    int n;
    bit got;
    model(r, l, lat, ne, uc);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    r_in  = 13'($urandom);
    check("busy_after_start", int'(busy), 1);
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) begin
        got = 1;
      end else begin
        check("busy_during_search", int'(busy), 1);
        if (n == pulse_n) begin
          start = 1'b1;
          r_in  = 13'(pulse_r);
        end else if (n == pulse_n + 1) begin
          start = 1'b0;
        end
      end
    end
    check("done_seen", int'(got), 1);
    check("latency", n, lat);
    check("l_out", sl(l_out), l);
    check("no_err", int'(no_err), ne);
    check("uncorr", int'(uncorr), uc);
    check("busy_at_done", int'(busy), 0);
  endtask

  // Single op followed by a quiet cycle: done must drop, results must hold.
  task automatic single(input int r, input int pulse_n, input int pulse_r);
    int l, lat, ne, uc;
    model(r, l, lat, ne, uc);
    launch(r);
    collect(r, pulse_n, pulse_r);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("l_out_hold", sl(l_out), l);
    check("uncorr_hold", int'(uncorr), uc);
  endtask

  int dir_list[$];
  int sweep[$];
  longint pw;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    r_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_l_out", sl(l_out), 0);
    check("rst_no_err", int'(no_err), 0);
    check("rst_uncorr", int'(uncorr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    dir_list = '{1, 4546, 4096, 451, 3645, 3311, 1236, 0, 4547, 8191};
    foreach (dir_list[j]) single(dir_list[j], 0, 0);
    check("neg29_bits", int'(l_out == 6'b100011), 0);

    // -29 encoding explicitly, then a stray start mid-search must be ignored.
    single(1236, 0, 0);
    check("neg29_bits_after_1236", int'(l_out), 35);
    single(1236, 5, 1);

    // Asynchronous reset between edges clears outputs without a clock edge.
    single(4546, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_l_out", sl(l_out), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset at E10 of a long search: aborted, no done afterwards.
    launch(1236);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_l_out", sl(l_out), 0);
    check("abort_uncorr", int'(uncorr), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    single(1236, 0, 0);

    // Back-to-back sweep: every golden remainder, boundaries, random picks.
    for (int k = 1; k <= NPOS; k++) begin
      pw = (longint'(1) << (k - 1)) % A;
      sweep.push_back(int'(pw));
      sweep.push_back(A - int'(pw));
    end
    sweep.push_back(0);
    sweep.push_back(A - 1);
    sweep.push_back(A);
    sweep.push_back(8191);
    for (int j = 0; j < 900; j++) sweep.push_back(int'($urandom_range(0, 8191)));
    for (int j = 0; j < 300; j++) sweep.push_back(int'($urandom_range(4547, 8191)));

    launch(sweep[0]);
    for (int j = 0; j < sweep.size(); j++) begin
      collect(sweep[j], 0, 0);
      if (j + 1 < sweep.size()) launch(sweep[j + 1]);
      else start = 1'b0;
    end
    @(negedge clk);
    check("sweep_done_drop", int'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
